// File: rtl/cpu_pkg.sv
// Shared CPU types and default widths, mirroring CPU_define.vh.
package cpu_pkg;

    localparam int CPU_NUM_REGS = 32;
    localparam int CPU_XLEN     = 32;

    typedef struct packed {
        logic reg_write;
        logic mem_to_reg;
    } writeback_t;

    typedef enum logic {
        RUN      = 1'b0,
        WAIT_MEM = 1'b1
    } fsm_commit_t;

endpackage

// File: rtl/cpu_load_wait_fsm.sv
// Load-wait controller: tracks how long a load in commit has waited on memory
// and aborts it with a one-cycle mem_timeout pulse once the limit is reached.
module cpu_load_wait_fsm
    import cpu_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic stall,
    input  logic mem_ready,
    input  logic flush,
    output logic abort,
    output logic mem_timeout
);

    localparam int WCW = $clog2(MEM_TIMEOUT + 1);

    fsm_commit_t    state_q, state_d;
    logic [WCW-1:0] wcnt_q, wcnt_d;
    logic           timeout_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= RUN;
            wcnt_q      <= '0;
            mem_timeout <= 1'b0;
        end else begin
            state_q     <= state_d;
            wcnt_q      <= wcnt_d;
            mem_timeout <= timeout_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        wcnt_d    = wcnt_q;
        timeout_d = 1'b0;
        abort     = 1'b0;
        if (flush) begin
            state_d = RUN;
            wcnt_d  = '0;
        end else begin
            case (state_q)
                RUN: begin
                    if (stall) begin
                        state_d = WAIT_MEM;
                        wcnt_d  = WCW'(1);
                    end
                end
                WAIT_MEM: begin
                    if (mem_ready) begin
                        state_d = RUN;
                        wcnt_d  = '0;
                    end else if (wcnt_q == WCW'(MEM_TIMEOUT)) begin
                        // Give up on the load: the top drops the commit entry this edge.
                        state_d   = RUN;
                        wcnt_d    = '0;
                        timeout_d = 1'b1;
                        abort     = 1'b1;
                    end else begin
                        wcnt_d = wcnt_q + WCW'(1);
                    end
                end
                default: begin
                    state_d = RUN;
                    wcnt_d  = '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/cpu_commit_wb_stage.sv
// Commit/writeback stage: commit and writeback pipeline registers, load-data wait,
// register-file write port and forwarding taps. Load waiting enabled by CPU_COMMIT_LOAD_WAIT_EN.
module cpu_commit_wb_stage
    import cpu_pkg::*;
#(
    parameter int  NUM_REGS    = CPU_NUM_REGS,
    parameter int  XLEN        = CPU_XLEN,
    parameter int  MEM_TIMEOUT = 16,
    localparam int RW          = $clog2(NUM_REGS)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [RW-1:0]   in_reg_dest,
    input  writeback_t      in_write_back,
    input  logic [XLEN-1:0] in_result,
    input  logic            flush,
    input  logic [XLEN-1:0] mem_rdata,
    input  logic            mem_ready,
    output logic [RW-1:0]   reg_dest_commit,
    output writeback_t      write_back_commit,
    output logic [XLEN-1:0] commit_value,
    output logic [RW-1:0]   reg_dest_wb,
    output writeback_t      write_back_wb,
    output logic [XLEN-1:0] wb_value,
    output logic            rf_we,
    output logic [RW-1:0]   rf_waddr,
    output logic [XLEN-1:0] rf_wdata,
    output logic            mem_timeout
);

    logic            c_vld_p1;
    logic [RW-1:0]   c_dest_p1;
    writeback_t      c_wb_p1;
    logic [XLEN-1:0] c_result_p1;

    logic            w_vld_p2;
    logic [RW-1:0]   w_dest_p2;
    writeback_t      w_wb_p2;
    logic [XLEN-1:0] w_value_p2;

    logic mem_rdy_eff;
    logic stall;
    logic abort;
    logic xfer;

`ifdef CPU_COMMIT_LOAD_WAIT_EN
    assign mem_rdy_eff = mem_ready;

    cpu_load_wait_fsm #(
        .MEM_TIMEOUT (MEM_TIMEOUT)
    ) u_load_wait (
        .clk         (clk),
        .rst_n       (rst_n),
        .stall       (stall),
        .mem_ready   (mem_ready),
        .flush       (flush),
        .abort       (abort),
        .mem_timeout (mem_timeout)
    );
`else
    // Memory is assumed to answer in the load's commit cycle.
    localparam int unused_mem_timeout = MEM_TIMEOUT;
    logic unused_mem_ready;
    assign unused_mem_ready = mem_ready;
    assign mem_rdy_eff      = 1'b1;
    assign abort            = 1'b0;
    assign mem_timeout      = 1'b0;
`endif

    assign stall    = c_vld_p1 && c_wb_p1.mem_to_reg && !mem_rdy_eff;
    assign in_ready = !stall;
    assign xfer     = in_valid && in_ready && !flush;

    // ---- commit stage (p1) ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c_vld_p1    <= 1'b0;
            c_dest_p1   <= '0;
            c_wb_p1     <= '0;
            c_result_p1 <= '0;
        end else if (flush) begin
            c_vld_p1 <= 1'b0;
        end else if (xfer) begin
            c_vld_p1    <= 1'b1;
            c_dest_p1   <= in_reg_dest;
            c_wb_p1     <= in_write_back;
            c_result_p1 <= in_result;
        end else if (!stall || abort) begin
            c_vld_p1 <= 1'b0;
        end
    end

    // ---- writeback stage (p2) ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_vld_p2   <= 1'b0;
            w_dest_p2  <= '0;
            w_wb_p2    <= '0;
            w_value_p2 <= '0;
        end else if (stall || flush) begin
            w_vld_p2 <= 1'b0;
        end else begin
            w_vld_p2   <= c_vld_p1;
            w_dest_p2  <= c_dest_p1;
            w_wb_p2    <= c_wb_p1;
            w_value_p2 <= c_wb_p1.mem_to_reg ? mem_rdata : c_result_p1;
        end
    end

    // Bubbles and r0 never look like writers to the forwarding unit or the register file.
    assign reg_dest_commit   = c_dest_p1;
    assign write_back_commit = '{reg_write:  c_vld_p1 && c_wb_p1.reg_write && (c_dest_p1 != '0),
                                 mem_to_reg: c_wb_p1.mem_to_reg};
    assign commit_value      = c_result_p1;

    assign reg_dest_wb   = w_dest_p2;
    assign write_back_wb = '{reg_write:  w_vld_p2 && w_wb_p2.reg_write && (w_dest_p2 != '0),
                             mem_to_reg: w_wb_p2.mem_to_reg};
    assign wb_value      = w_value_p2;

    assign rf_we    = write_back_wb.reg_write;
    assign rf_waddr = w_dest_p2;
    assign rf_wdata = w_value_p2;

endmodule

// File: tb/tb_cpu_commit_wb_stage.sv
// Bench for cpu_commit_wb_stage: directed scenarios plus randomized traffic against
// a transaction-level model of the stage.
module tb_cpu_commit_wb_stage;
    import cpu_pkg::*;

    localparam int NR = 32;
    localparam int XL = 32;
    localparam int RW = 5;
    localparam int MT = 4;

    logic            clk;
    logic            rst_n;
    logic            in_valid;
    logic            in_ready;
    logic [RW-1:0]   in_reg_dest;
    writeback_t      in_write_back;
    logic [XL-1:0]   in_result;
    logic            flush;
    logic [XL-1:0]   mem_rdata;
    logic            mem_ready;
    logic [RW-1:0]   reg_dest_commit;
    writeback_t      write_back_commit;
    logic [XL-1:0]   commit_value;
    logic [RW-1:0]   reg_dest_wb;
    writeback_t      write_back_wb;
    logic [XL-1:0]   wb_value;
    logic            rf_we;
    logic [RW-1:0]   rf_waddr;
    logic [XL-1:0]   rf_wdata;
    logic            mem_timeout;

    int checks = 0;
    int failures = 0;

    cpu_commit_wb_stage #(
        .NUM_REGS    (NR),
        .XLEN        (XL),
        .MEM_TIMEOUT (MT)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .in_valid          (in_valid),
        .in_ready          (in_ready),
        .in_reg_dest       (in_reg_dest),
        .in_write_back     (in_write_back),
        .in_result         (in_result),
        .flush             (flush),
        .mem_rdata         (mem_rdata),
        .mem_ready         (mem_ready),
        .reg_dest_commit   (reg_dest_commit),
        .write_back_commit (write_back_commit),
        .commit_value      (commit_value),
        .reg_dest_wb       (reg_dest_wb),
        .write_back_wb     (write_back_wb),
        .wb_value          (wb_value),
        .rf_we             (rf_we),
        .rf_waddr          (rf_waddr),
        .rf_wdata          (rf_wdata),
        .mem_timeout       (mem_timeout)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (observed=timeout expected=finish)");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_valid      = 1'b0;
        in_reg_dest   = '0;
        in_write_back = '0;
        in_result     = '0;
        flush         = 1'b0;
    endtask

    task automatic set_in(input logic [RW-1:0] d, input logic rw, input logic m2r,
                          input logic [XL-1:0] r);
        in_valid      = 1'b1;
        in_reg_dest   = d;
        in_write_back = '{reg_write: rw, mem_to_reg: m2r};
        in_result     = r;
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_dest_commit"}, 64'(reg_dest_commit), 64'd0);
        chk({tag, "_wb_commit"},   64'(write_back_commit), 64'd0);
        chk({tag, "_commit_val"},  64'(commit_value), 64'd0);
        chk({tag, "_dest_wb"},     64'(reg_dest_wb), 64'd0);
        chk({tag, "_wb_wb"},       64'(write_back_wb), 64'd0);
        chk({tag, "_wb_value"},    64'(wb_value), 64'd0);
        chk({tag, "_rf_we"},       64'(rf_we), 64'd0);
        chk({tag, "_rf_waddr"},    64'(rf_waddr), 64'd0);
        chk({tag, "_rf_wdata"},    64'(rf_wdata), 64'd0);
        chk({tag, "_timeout"},     64'(mem_timeout), 64'd0);
    endtask

    // Transaction-level model state: the instruction waiting to retire and the
    // register-file write / timeout pulse expected in the current cycle.
    logic          p_valid, p_load, p_rw;
    logic [RW-1:0] p_dest;
    logic [XL-1:0] p_result;
    int            p_notready;
    logic          e_valid, e_to;
    logic [RW-1:0] e_dest;
    logic [XL-1:0] e_data;
    logic          n_valid, n_to, rdy, exp_rdy;
    logic [RW-1:0] n_dest;
    logic [XL-1:0] n_data;

    initial begin
        rst_n     = 1'b0;
        mem_ready = 1'b0;
        mem_rdata = '0;
        idle();

        // Reset values
        #3;
        chk_outputs_zero("reset");
        chk("reset_in_ready", 64'(in_ready), 64'd1);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // ALU write r5 = 0x1234
        cyc(); set_in(5'd5, 1'b1, 1'b0, 32'h0000_1234); #2;
        chk("alu_in_ready", 64'(in_ready), 64'd1);
        cyc(); idle(); #2;
        chk("alu_commit_dest", 64'(reg_dest_commit), 64'd5);
        chk("alu_commit_rw", 64'(write_back_commit.reg_write), 64'd1);
        chk("alu_commit_val", 64'(commit_value), 64'h1234);
        chk("alu_rf_we_early", 64'(rf_we), 64'd0);
        cyc(); #2;
        chk("alu_rf_we", 64'(rf_we), 64'd1);
        chk("alu_rf_waddr", 64'(rf_waddr), 64'd5);
        chk("alu_rf_wdata", 64'(rf_wdata), 64'h1234);
        chk("alu_dest_wb", 64'(reg_dest_wb), 64'd5);
        cyc(); #2;
        chk("alu_rf_we_after", 64'(rf_we), 64'd0);

        // Load to r7
        cyc(); set_in(5'd7, 1'b1, 1'b1, 32'h0000_0100); mem_ready = 1'b0; #2;
        chk("ld_accept", 64'(in_ready), 64'd1);
`ifdef CPU_COMMIT_LOAD_WAIT_EN
        for (int i = 0; i < 3; i++) begin
            cyc(); idle(); mem_ready = 1'b0; mem_rdata = $urandom; #2;
            chk("ld_stall_in_ready", 64'(in_ready), 64'd0);
            chk("ld_stall_rf_we", 64'(rf_we), 64'd0);
            chk("ld_stall_wb_bubble", 64'(write_back_wb.reg_write), 64'd0);
        end
        cyc(); mem_ready = 1'b1; mem_rdata = 32'hDEAD_BEEF; #2;
        chk("ld_ready_in_ready", 64'(in_ready), 64'd1);
        chk("ld_ready_rf_we", 64'(rf_we), 64'd0);
`else
        cyc(); idle(); mem_ready = 1'b0; mem_rdata = 32'hDEAD_BEEF; #2;
        chk("ld_nowait_in_ready", 64'(in_ready), 64'd1);
        chk("ld_nowait_timeout", 64'(mem_timeout), 64'd0);
`endif
        cyc(); mem_ready = 1'b0; mem_rdata = $urandom; #2;
        chk("ld_rf_we", 64'(rf_we), 64'd1);
        chk("ld_rf_waddr", 64'(rf_waddr), 64'd7);
        chk("ld_rf_wdata", 64'(rf_wdata), 64'hDEAD_BEEF);
        cyc(); #2;
        chk("ld_rf_we_once", 64'(rf_we), 64'd0);

        // Write to r0 is suppressed everywhere
        cyc(); set_in(5'd0, 1'b1, 1'b0, 32'h0000_0055); #2;
        cyc(); idle(); #2;
        chk("r0_commit_rw", 64'(write_back_commit.reg_write), 64'd0);
        cyc(); #2;
        chk("r0_rf_we", 64'(rf_we), 64'd0);
        chk("r0_wb_rw", 64'(write_back_wb.reg_write), 64'd0);

`ifdef CPU_COMMIT_LOAD_WAIT_EN
        // Load that never gets data
        cyc(); set_in(5'd9, 1'b1, 1'b1, 32'h0000_0200); mem_ready = 1'b0; #2;
        for (int i = 0; i < MT + 1; i++) begin
            cyc(); idle(); #2;
            chk("to_stall_in_ready", 64'(in_ready), 64'd0);
            chk("to_no_pulse_yet", 64'(mem_timeout), 64'd0);
            chk("to_stall_rf_we", 64'(rf_we), 64'd0);
        end
        cyc(); #2;
        chk("to_pulse", 64'(mem_timeout), 64'd1);
        chk("to_in_ready_back", 64'(in_ready), 64'd1);
        chk("to_rf_we", 64'(rf_we), 64'd0);
        cyc(); #2;
        chk("to_pulse_once", 64'(mem_timeout), 64'd0);
        chk("to_rf_we_after", 64'(rf_we), 64'd0);
`endif

        // Flush while a load waits, with an ALU write to r3 ahead of it
        cyc(); set_in(5'd3, 1'b1, 1'b0, 32'h0000_0033); mem_ready = 1'b0; #2;
        cyc(); set_in(5'd10, 1'b1, 1'b1, 32'h0000_0300); #2;
        chk("fl_load_accept", 64'(in_ready), 64'd1);
        cyc(); idle();
`ifndef CPU_COMMIT_LOAD_WAIT_EN
        flush = 1'b1; mem_ready = 1'b1; mem_rdata = 32'h0BAD_0BAD;
        set_in(5'd11, 1'b1, 1'b0, 32'h0000_0011);
`endif
        #2;
        chk("fl_r3_we", 64'(rf_we), 64'd1);
        chk("fl_r3_addr", 64'(rf_waddr), 64'd3);
        chk("fl_r3_data", 64'(rf_wdata), 64'h33);
`ifdef CPU_COMMIT_LOAD_WAIT_EN
        chk("fl_stalled", 64'(in_ready), 64'd0);
        cyc(); #2;
        chk("fl_wait1", 64'(in_ready), 64'd0);
        cyc(); flush = 1'b1; mem_ready = 1'b1; mem_rdata = 32'h0BAD_0BAD;
        set_in(5'd11, 1'b1, 1'b0, 32'h0000_0011); #2;
        chk("fl_in_ready_from_stall", 64'(in_ready), 64'd1);
`endif
        cyc(); idle(); mem_ready = 1'b0; #2;
        chk("fl_in_ready_after", 64'(in_ready), 64'd1);
        chk("fl_commit_empty", 64'(write_back_commit.reg_write), 64'd0);
        chk("fl_load_dropped", 64'(rf_we), 64'd0);
        for (int i = 0; i < MT + 3; i++) begin
            cyc(); #2;
            chk("fl_quiet_we", 64'(rf_we), 64'd0);
            chk("fl_quiet_timeout", 64'(mem_timeout), 64'd0);
        end

        // Asynchronous reset in the middle of a load wait
        cyc(); set_in(5'd12, 1'b1, 1'b1, 32'h0000_0400); mem_ready = 1'b0; #2;
        cyc(); idle(); #2;
        cyc(); #2;
        rst_n = 1'b0;
        #1;
        chk_outputs_zero("rst_mid");
        cyc(); cyc();
        rst_n = 1'b1; mem_ready = 1'b1; mem_rdata = 32'h1111_2222; #2;
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_rf_we", 64'(rf_we), 64'd0);
        cyc(); #2;
        chk("rst_rf_we_next", 64'(rf_we), 64'd0);

        // Randomized traffic against the transaction model
        p_valid = 1'b0; p_load = 1'b0; p_rw = 1'b0; p_dest = '0; p_result = '0; p_notready = 0;
        e_valid = 1'b0; e_to = 1'b0; e_dest = '0; e_data = '0;
        for (int n = 0; n < 600; n++) begin
            cyc();
            in_valid      = ($urandom_range(0, 3) != 0);
            in_reg_dest   = ($urandom_range(0, 5) == 0) ? 5'd0 : RW'($urandom_range(1, NR - 1));
            in_write_back = writeback_t'($urandom_range(0, 3));
            in_result     = $urandom;
            mem_ready     = ($urandom_range(0, 9) < 4);
            mem_rdata     = $urandom;
            flush         = ($urandom_range(0, 24) == 0);
            #2;
`ifdef CPU_COMMIT_LOAD_WAIT_EN
            rdy = mem_ready;
`else
            rdy = 1'b1;
`endif
            exp_rdy = !(p_valid && p_load && !rdy);
            chk("rnd_in_ready", 64'(in_ready), 64'(exp_rdy));
            chk("rnd_rf_we", 64'(rf_we), 64'(e_valid));
            if (e_valid) begin
                chk("rnd_rf_waddr", 64'(rf_waddr), 64'(e_dest));
                chk("rnd_rf_wdata", 64'(rf_wdata), 64'(e_data));
            end
            chk("rnd_timeout", 64'(mem_timeout), 64'(e_to));

            n_valid = 1'b0; n_to = 1'b0; n_dest = e_dest; n_data = e_data;
            if (flush) begin
                p_valid = 1'b0;
            end else if (p_valid) begin
                if (!p_load || rdy) begin
                    if (p_rw && p_dest != 0) begin
                        n_valid = 1'b1;
                        n_dest  = p_dest;
                        n_data  = p_load ? mem_rdata : p_result;
                    end
                    p_valid = 1'b0;
                end else if (p_notready == MT) begin
                    // This is the (MT+1)th cycle without data: the load is abandoned.
                    n_to    = 1'b1;
                    p_valid = 1'b0;
                end else begin
                    p_notready++;
                end
            end
            if (in_valid && exp_rdy && !flush) begin
                p_valid    = 1'b1;
                p_load     = in_write_back.mem_to_reg;
                p_rw       = in_write_back.reg_write;
                p_dest     = in_reg_dest;
                p_result   = in_result;
                p_notready = 0;
            end
            e_valid = n_valid; e_to = n_to; e_dest = n_dest; e_data = n_data;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
